// File: rtl/accel_pkg.sv
// +-----------------------------------------------------------------------------+
// | accel_pkg: ADXL362 command/register constants, sequencer states, byte table |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package accel_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_XDATA     = 8'h08;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;

    typedef enum logic [2:0] {
        BOOT,
        CFG,
        GAP,
        WAIT,
        READ,
        UPDATE
    } state_t;

    // Outgoing byte for position idx of the configuration or read transaction.
    function automatic logic [7:0] tx_byte_for(input logic is_read, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (is_read) begin
            case (idx)
                2'd0:    b = CMD_READ;
                2'd1:    b = REG_XDATA;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                2'd0:    b = CMD_WRITE;
                2'd1:    b = REG_POWER_CTL;
                2'd2:    b = PWR_MEASURE;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_engine.sv
// +-----------------------------------------------------------------------------+
// | spi_byte_engine: mode-0 MSB-first byte shifter; chains bytes while cont=1    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module spi_byte_engine #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cont,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sclk,
    output logic       mosi
);

    localparam int           CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // done marks the cycle before the last falling edge; tx_byte is taken there when cont is set.
    always_comb begin
        done = busy && sclk && (cnt == DIV_LAST) && (bit_idx == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            rx_byte <= 8'h00;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (start && !busy) begin
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= 3'd0;
            sclk    <= 1'b0;
            shreg   <= tx_byte;
            mosi    <= tx_byte[7];
        end else if (busy) begin
            if (cnt == DIV_LAST) begin
                cnt  <= '0;
                sclk <= ~sclk;
                if (!sclk) begin
                    rx_byte <= {rx_byte[6:0], miso};
                end else if (bit_idx == 3'd7) begin
                    bit_idx <= 3'd0;
                    if (cont) begin
                        shreg <= tx_byte;
                        mosi  <= tx_byte[7];
                    end else begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end
                end else begin
                    bit_idx <= bit_idx + 3'd1;
                    shreg   <= {shreg[6:0], 1'b0};
                    mosi    <= shreg[6];
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/accel_spi_reader.sv
// +-----------------------------------------------------------------------------+
// | accel_spi_reader: configures the ADXL362, reads X/Y periodically and emits   |
// | {X5,Y5} with a valid strobe. Define ACCEL_AVG_EN for two-sample averaging.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module accel_spi_reader
    import accel_pkg::*;
#(
    parameter int CLK_DIV       = 50,
    parameter int SAMPLE_PERIOD = 1_000_000,
    parameter int BOOT_WAIT     = 600_000,
    parameter int CS_GAP        = 100
) (
    input  logic       in_clk,
    input  logic       reset,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [9:0] movementData,
    output logic       data_valid
);

    localparam logic [31:0] BOOT_LAST = 32'(BOOT_WAIT);
    localparam logic [31:0] GAP_LAST  = 32'(CS_GAP - 1);
    localparam logic [31:0] SAMP_LAST = 32'(SAMPLE_PERIOD - 1);
    localparam logic [31:0] TAIL_LAST = 32'(CLK_DIV - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] samp_cnt;
    logic [1:0]  byte_idx;
    logic        tail;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic [4:0]  x5;
    logic [4:0]  y5;

    logic        start;
    logic        cont;
    logic        done;
    logic        is_read;
    logic [1:0]  tx_idx;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;

    always_comb begin
        start   = ((state == BOOT) && (cnt == BOOT_LAST)) ||
                  ((state == WAIT) && (samp_cnt == SAMP_LAST));
        is_read = (state == WAIT) || (state == READ);
        tx_idx  = start ? 2'd0 : byte_idx + 2'd1;
        tx_byte = tx_byte_for(is_read, tx_idx);
        cont    = (state == READ) ? (byte_idx != 2'd3) : (byte_idx != 2'd2);
    end

`ifdef ACCEL_AVG_EN
    logic [7:0] prev_x;
    logic [7:0] prev_y;
    logic [8:0] sum_x;
    logic [8:0] sum_y;

    // Bits [8:4] of the 9-bit sum are (sum >>> 1)[7:3].
    always_comb begin
        sum_x = {x8[7], x8} + {prev_x[7], prev_x};
        sum_y = {y8[7], y8} + {prev_y[7], prev_y};
        x5    = sum_x[8:4];
        y5    = sum_y[8:4];
    end

    always_ff @(posedge in_clk) begin
        if (!reset) begin
            prev_x <= 8'h00;
            prev_y <= 8'h00;
        end else if (state == UPDATE) begin
            prev_x <= x8;
            prev_y <= y8;
        end
    end
`else
    always_comb begin
        x5 = x8[7:3];
        y5 = y8[7:3];
    end
`endif

    spi_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk     (in_clk),
        .reset   (reset),
        .start   (start),
        .cont    (cont),
        .tx_byte (tx_byte),
        .miso    (miso),
        .rx_byte (rx_byte),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi)
    );

    always_ff @(posedge in_clk) begin
        if (!reset) begin
            state        <= BOOT;
            cnt          <= 32'd0;
            samp_cnt     <= 32'd0;
            byte_idx     <= 2'd0;
            tail         <= 1'b0;
            cs_n         <= 1'b1;
            x8           <= 8'h00;
            y8           <= 8'h00;
            movementData <= 10'd0;
            data_valid   <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            // Saturated before the first read so the first WAIT expires at once.
            if ((state == BOOT) || (state == CFG)) begin
                samp_cnt <= SAMP_LAST;
            end else if (start) begin
                samp_cnt <= 32'd0;
            end else if (samp_cnt != SAMP_LAST) begin
                samp_cnt <= samp_cnt + 32'd1;
            end

            case (state)
                BOOT: begin
                    if (start) begin
                        state    <= CFG;
                        cs_n     <= 1'b0;
                        cnt      <= 32'd0;
                        byte_idx <= 2'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CFG, READ: begin
                    if (tail) begin
                        if (cnt == TAIL_LAST) begin
                            cs_n  <= 1'b1;
                            tail  <= 1'b0;
                            cnt   <= 32'd0;
                            state <= (state == READ) ? UPDATE : GAP;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end else if (done) begin
                        if ((state == READ) && (byte_idx == 2'd2)) x8 <= rx_byte;
                        if ((state == READ) && (byte_idx == 2'd3)) y8 <= rx_byte;
                        if (cont) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            tail <= 1'b1;
                            cnt  <= 32'd0;
                        end
                    end
                end
                GAP: begin
                    if (cnt >= GAP_LAST) begin
                        state <= WAIT;
                        cnt   <= 32'd0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (start) begin
                        state    <= READ;
                        cs_n     <= 1'b0;
                        byte_idx <= 2'd0;
                    end
                end
                UPDATE: begin
                    movementData <= {x5, y5};
                    data_valid   <= 1'b1;
                    state        <= GAP;
                    cnt          <= 32'd0;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_accel_spi_reader.sv
// +-----------------------------------------------------------------------------+
// | tb_accel_spi_reader: sensor model, SPI bus monitor and scoreboard            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_accel_spi_reader;

    localparam int D  = 4;
    localparam int P  = 2000;
    localparam int BW = 200;
    localparam int CG = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       miso  = 1'b0;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic [9:0] md;
    logic       data_valid;

    accel_spi_reader #(
        .CLK_DIV       (D),
        .SAMPLE_PERIOD (P),
        .BOOT_WAIT     (BW),
        .CS_GAP        (CG)
    ) dut (
        .in_clk       (clk),
        .reset        (reset),
        .miso         (miso),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_n         (cs_n),
        .movementData (md),
        .data_valid   (data_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Sensor: shifts {0x00, 0x00, X, Y} MSB first, new bit after each SCLK fall.
    logic [7:0]  sens_x = 8'h00;
    logic [7:0]  sens_y = 8'h00;
    logic [31:0] stream;
    int          sidx;
    bit          s_active = 1'b0;

    initial forever begin
        @(negedge cs_n or negedge sclk or posedge cs_n);
        if (cs_n === 1'b0) begin
            if (!s_active) begin
                s_active = 1'b1;
                stream   = {16'h0000, sens_x, sens_y};
                sidx     = 0;
            end else begin
                sidx = sidx + 1;
            end
            miso = (sidx < 32) ? stream[31 - sidx] : 1'b0;
        end else begin
            s_active = 1'b0;
        end
    end

    // Bus monitor, sampled mid-cycle.
    bit          prev_cs = 1'b1;
    bit          prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    int          t_fall = 0, t_rise = 0, first_rise = -1, last_rise = 0, last_fall = 0;
    int          mon_nb = 0;
    logic [31:0] bits = 32'd0;
    int          r_nb = 0, r_first = 0, r_tail = 0, r_len = 0;
    logic [31:0] r_bits = 32'd0;
    int          txn_count = 0, per_bad = 0, viol = 0, min_gap = 1000000;
    bit          gap_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (prev_cs && !cs_n) begin
            if (gap_en && (cyc - t_rise < min_gap)) min_gap = cyc - t_rise;
            t_fall     = cyc;
            mon_nb     = 0;
            bits       = 32'd0;
            first_rise = -1;
        end else if (!prev_cs && !cs_n && (mosi !== prev_mosi) && !(prev_sclk && !sclk)) begin
            viol = viol + 1;
        end
        if (!cs_n && !prev_sclk && sclk) begin
            bits   = {bits[30:0], mosi};
            mon_nb = mon_nb + 1;
            if (first_rise < 0) first_rise = cyc;
            else if (cyc - last_rise != 2 * D) per_bad = per_bad + 1;
            last_rise = cyc;
        end
        if (!cs_n && prev_sclk && !sclk) last_fall = cyc;
        if (!prev_cs && cs_n) begin
            t_rise    = cyc;
            r_nb      = mon_nb;
            r_bits    = bits;
            r_first   = first_rise - t_fall;
            r_tail    = cyc - last_fall;
            r_len     = cyc - t_fall;
            txn_count = txn_count + 1;
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    // Reference model: signed sample, optional floor average with previous, floor divide by 8.
    int px = 0, py = 0;

    function automatic int s8(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    function automatic int fdiv(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    function automatic logic [4:0] enc5(input int v);
        logic [31:0] t;
        t = v;
        return t[4:0];
    endfunction

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        int vx, vy;
        vx = s8(x);
        vy = s8(y);
`ifdef ACCEL_AVG_EN
        vx = fdiv(vx + px, 2);
        vy = fdiv(vy + py, 2);
`endif
        px = s8(x);
        py = s8(y);
        return {enc5(fdiv(vx, 8)), enc5(fdiv(vy, 8))};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs_n"}, int'(cs_n), 1);
        check({tag, "_sclk"}, int'(sclk), 0);
        check({tag, "_mosi"}, int'(mosi), 0);
        check({tag, "_md"}, int'(md), 0);
        check({tag, "_dv"}, int'(data_valid), 0);
    endtask

    task automatic wait_txn(input int limit, output bit ok);
        int n0;
        n0 = txn_count;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (txn_count != n0) begin
                ok = 1'b1;
                break;
            end
        end
        check("txn_seen", int'(ok), 1);
    endtask

    task automatic do_boot();
        int n;
        bit ok;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (n < BW + 20) begin
            @(posedge clk); #1;
            n = n + 1;
            if (!cs_n) break;
        end
        check("boot_hold", n - 1, BW);
        wait_txn(60 * D, ok);
        if (ok) begin
            check("cfg_nbits", r_nb, 24);
            check("cfg_bytes", int'(r_bits[23:0]), 32'h0A2D02);
            check("cfg_first_rise", r_first, D);
            check("cfg_tail", r_tail, D);
            check("cfg_len", r_len, 49 * D);
        end
    endtask

    int          last_dv = 0;
    logic [9:0]  last_md = 10'd0;

    task automatic do_read(input logic [9:0] exp, input bit spacing);
        bit ok;
        int tdv;
        ok = 1'b0;
        for (int k = 0; k < 3 * P; k++) begin
            @(posedge clk); #1;
            if (data_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("dv_seen", int'(ok), 1);
        if (ok) begin
            tdv = cyc;
            check("md", int'(md), int'(exp));
            check("dv_latency", tdv - t_rise, 1);
            check("rd_bytes", int'(r_bits), 32'h0B080000);
            check("rd_nbits", r_nb, 32);
            check("rd_len", r_len, 65 * D);
            check("rd_first_rise", r_first, D);
            check("rd_tail", r_tail, D);
            if (spacing) check("dv_period", tdv - last_dv, P);
            last_dv = tdv;
            last_md = exp;
            @(posedge clk); #1;
            check("dv_width", int'(data_valid), 0);
        end
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [9:0] exp_raw;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [9:0] e;
        bit         ok;

        tbl[0] = '{8'h40, 8'hC0, 10'b01000_11000};
        tbl[1] = '{8'h00, 8'h00, 10'b00000_00000};
        tbl[2] = '{8'h7F, 8'h80, 10'b01111_10000};
        tbl[3] = '{8'h07, 8'hF8, 10'b00000_11111};

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");

        sens_x = tbl[0].x;
        sens_y = tbl[0].y;
        do_boot();
        gap_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            sens_x = tbl[i].x;
            sens_y = tbl[i].y;
            e = model(tbl[i].x, tbl[i].y);
`ifndef ACCEL_AVG_EN
            e = tbl[i].exp_raw;
`endif
            do_read(e, i > 0);
        end

        for (int i = 0; i < 5; i++) begin
            sens_x = 8'($urandom_range(0, 255));
            sens_y = 8'($urandom_range(0, 255));
            do_read(model(sens_x, sens_y), 1'b1);
        end

        gap_en = 1'b0;
        check("cs_gap_ok", int'(min_gap >= CG), 1);
        check("sclk_period_errs", per_bad, 0);
        check("mosi_change_errs", viol, 0);

        // Reset during byte 3 of a read while SCLK is high.
        sens_x = 8'h55;
        sens_y = 8'hAA;
        ok = 1'b0;
        for (int k = 0; k < 3 * P; k++) begin
            @(posedge clk); #1;
            if (!cs_n && mon_nb >= 17 && sclk) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_read_reached", int'(ok), 1);
        check("partial_hold_md", int'(md), int'(last_md));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_state("midrst");
        px = 0;
        py = 0;
        repeat (3) @(posedge clk);

        sens_x = 8'h40;
        sens_y = 8'hC0;
        do_boot();
        do_read(model(8'h40, 8'hC0), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
